// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads 16-bit words from instruction memory and
// assembles 16- or 32-bit instructions for the decoder, with branch redirect.
module fetch_sequencer #(
    parameter logic [23:0] RESET_PC = 24'h000000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        run,
    input  logic        pc_load,
    input  logic [23:0] pc_load_addr,
    output logic        imem_req,
    output logic [23:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [31:0] instr_word,
    output logic        instr_long,
    output logic [23:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FETCH_LO = 2'd1;
    localparam logic [1:0] FETCH_HI = 2'd2;
    localparam logic [1:0] VALID    = 2'd3;

    logic [1:0]  state;
    logic [23:0] pc;
    logic        kill;
    logic [15:0] lo_word;
    logic [23:0] lo_pc;
    logic [23:0] restart_addr;
    logic        discard;

    // A redirect in the same cycle always wins over the sequential pc.
    always_comb begin
        restart_addr = pc_load ? pc_load_addr : pc;
        discard      = kill || pc_load;
    end

    // First half of a long instruction is staged here so that a killed second
    // word never leaves a partial instruction visible on the decoder outputs.
    always_ff @(posedge CLOCK_50) begin
        if (state == FETCH_LO && imem_ack && !discard) begin
            lo_word <= imem_data;
            lo_pc   <= imem_addr;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            kill        <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= 24'h000000;
            instr_valid <= 1'b0;
            instr_word  <= 32'h00000000;
            instr_long  <= 1'b0;
            instr_pc    <= 24'h000000;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_load) begin
                        pc <= pc_load_addr;
                    end
                    if (run) begin
                        state     <= FETCH_LO;
                        imem_req  <= 1'b1;
                        imem_addr <= restart_addr;
                    end
                end

                FETCH_LO, FETCH_HI: begin
                    if (imem_ack) begin
                        if (discard) begin
                            kill <= 1'b0;
                            if (pc_load) begin
                                pc <= pc_load_addr;
                            end
                            if (run) begin
                                state     <= FETCH_LO;
                                imem_req  <= 1'b1;
                                imem_addr <= restart_addr;
                            end else begin
                                state    <= IDLE;
                                imem_req <= 1'b0;
                            end
                        end else if (state == FETCH_LO) begin
                            pc <= pc + 24'd1;
                            if (imem_data[15]) begin
                                state     <= FETCH_HI;
                                imem_addr <= pc + 24'd1;
                            end else begin
                                state       <= VALID;
                                imem_req    <= 1'b0;
                                instr_valid <= 1'b1;
                                instr_word  <= {16'h0000, imem_data};
                                instr_long  <= 1'b0;
                                instr_pc    <= imem_addr;
                            end
                        end else begin
                            pc          <= pc + 24'd1;
                            state       <= VALID;
                            imem_req    <= 1'b0;
                            instr_valid <= 1'b1;
                            instr_word  <= {imem_data, lo_word};
                            instr_long  <= 1'b1;
                            instr_pc    <= lo_pc;
                        end
                    end else if (pc_load) begin
                        // Request must stay on the bus until acked; mark it stale.
                        pc   <= pc_load_addr;
                        kill <= 1'b1;
                    end
                end

                VALID: begin
                    if (pc_load || instr_ready) begin
                        instr_valid <= 1'b0;
                        if (pc_load) begin
                            pc <= pc_load_addr;
                        end
                        if (run) begin
                            state     <= FETCH_LO;
                            imem_req  <= 1'b1;
                            imem_addr <= restart_addr;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
